// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial addition sequencer wrapped around an external
// 1-bit full-adder cell. It feeds one operand bit pair per cycle, LSB first,
// and keeps the running carry in a flip-flop. It also collects the sum bits,
// then reports the result, carry and signed overflow with a one-cycle done pulse.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, op_a, op_b,    new request plus operands, sampled in IDLE only
//   cin_init
//   fa_a, fa_b, fa_cin    bit pair and running carry to the full adder
//   fa_sum, fa_cout       full-adder outputs
//   busy, done            activity flag and one-cycle completion pulse
//   result, carry_out,    sum, final carry and signed overflow
//   overflow
module serial_add_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_init,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d;
  logic [WIDTH-1:0]   sh_b_q, sh_b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_a_d   = op_a;
          sh_b_d   = op_b;
          carry_d  = cin_init;
          cnt_d    = '0;
          result_d = '0;
          ovf_d    = 1'b0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts
        result_d = {fa_sum, result_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        sh_a_d   = {1'b0, sh_a_q[WIDTH-1:1]};
        sh_b_d   = {1'b0, sh_b_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Signed overflow: carry into the MSB differs from carry out of it
          ovf_d   = carry_q ^ fa_cout;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags registered from the next state so they line up with it
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Adder inputs are forced low outside RUN so the cell sees no activity
  assign fa_a      = (state_q == S_RUN) & sh_a_q[0];
  assign fa_b      = (state_q == S_RUN) & sh_b_q[0];
  assign fa_cin    = (state_q == S_RUN) & carry_q;

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed bench for serial_add_seq with a behavioural
// 1-bit full adder attached to the fa_* ports.
module tb_serial_add_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin_init = 1'b0;
  logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin_init (cin_init),
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_cin   (fa_cin),
    .fa_sum   (fa_sum),
    .fa_cout  (fa_cout),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow)
  );

  // Behavioural full-adder cell
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: hand-computed expectations, optional ignored start pulse
  // during RUN bit pulse_at, optional check of the LSB-first fa_a sequence.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] er, input logic ec, input logic eo,
                        input int pulse_at, input logic chk_seq, input logic [W-1:0] eseq);
    int lat, nbusy, idx;
    logic [W-1:0] seq;
    logic got_done;
    op_a = a; op_b = b; cin_init = c; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; nbusy = 0; idx = 0; seq = '0; got_done = 1'b0;
    for (int n = 1; n <= 20 && !got_done; n++) begin
      if (busy) nbusy++;
      if (busy && !done && idx < int'(W)) begin
        seq[idx] = fa_a;
        idx++;
      end
      if (pulse_at >= 0 && idx == pulse_at + 1 && busy && !done) begin
        start = 1'b1; op_a = 8'hFF; op_b = 8'hFF; cin_init = 1'b1;
      end else begin
        start = 1'b0; op_a = a; op_b = b; cin_init = c;
      end
      tick();
      if (done) begin
        got_done = 1'b1;
        lat = n;
      end
    end
    start = 1'b0;
    if (busy) nbusy++;
    check({name, "_latency"}, lat, W);
    check({name, "_result"}, result, er);
    check({name, "_carry"}, carry_out, ec);
    check({name, "_overflow"}, overflow, eo);
    check({name, "_busy_cycles"}, nbusy, W + 1);
    if (chk_seq) check({name, "_fa_a_seq"}, seq, eseq);
    tick();
    check({name, "_done_single"}, done, 1'b0);
    check({name, "_idle"}, busy, 1'b0);
    check({name, "_result_hold"}, result, er);
    check({name, "_carry_hold"}, carry_out, ec);
    check({name, "_fa_quiet"}, {fa_a, fa_b, fa_cin}, 3'b000);
  endtask

  initial begin
    logic [W:0]   exps;
    logic         expo;
    logic         prev_busy;
    int           acc_cnt, done_cnt, last_acc;
    logic [W-1:0] ra, rb;
    logic         rc;

    // Reset state
    repeat (2) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_flags", {carry_out, overflow}, 2'b00);
    check("rst_fa", {fa_a, fa_b, fa_cin}, 3'b000);
    rst_n = 1'b1;

    run_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, -1, 1'b1, 8'h5A);
    run_op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1, 1'b0, 8'h00);
    run_op("add7f00c", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, -1, 1'b0, 8'h00);
    run_op("ignstart", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 3, 1'b0, 8'h00);

    // Asynchronous reset in the middle of RUN
    op_a = 8'hFF; op_b = 8'hFF; cin_init = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("midrun_active", {busy, fa_a, fa_b, fa_cin}, 4'b1111);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_result", result, 8'h00);
    check("midrst_fa", {fa_a, fa_b, fa_cin}, 3'b000);
    check("midrst_flags", {done, carry_out, overflow}, 3'b000);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) check("midrst_no_done", done, 1'b0);
    end
    rst_n = 1'b1;
    run_op("add0101", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, -1, 1'b0, 8'h00);

    // Start held high: back-to-back operations with random operands
    ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
    op_a = ra; op_b = rb; cin_init = rc; start = 1'b1;
    prev_busy = busy;
    acc_cnt = 0; done_cnt = 0; last_acc = -1;
    exps = '0; expo = 1'b0;
    for (int cyc = 0; cyc < 120 && done_cnt < 6; cyc++) begin
      tick();
      if (busy && !prev_busy) begin
        if (acc_cnt > 0) check("burst_gap", cyc - last_acc, 10);
        last_acc = cyc;
        acc_cnt++;
        exps = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin_init};
        expo = (op_a[W-1] == op_b[W-1]) && (exps[W-1] != op_a[W-1]);
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
        op_a = ra; op_b = rb; cin_init = rc;
      end
      if (done) begin
        check("burst_result", result, exps[W-1:0]);
        check("burst_carry", carry_out, exps[W]);
        check("burst_overflow", overflow, expo);
        done_cnt++;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    check("burst_dones", done_cnt, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
